// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array operand skew feeder.
package sa_pkg;
   localparam int DEFAULT_DATA_WIDTH = 16;

   typedef enum logic [2:0] {
      LOAD,
      FULL,
      STREAM,
      DRAIN,
      DONE
   } sa_state_e;

   // Index width for a table of 'depth' entries, never narrower than one bit.
   function automatic int lane_idx(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/sa_lane_buffer.sv
// K-deep operand store for one lane of the skew feeder, with a registered,
// valid-gated read port so idle lanes present zero to the array edge.
module sa_lane_buffer import sa_pkg::*; #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int K          = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [lane_idx(K)-1:0]        wr_idx,
   input  logic [DATA_WIDTH-1:0]         wr_data,
   input  logic                          rd_en,
   input  logic [lane_idx(K)-1:0]        rd_idx,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_valid
);
   logic [DATA_WIDTH-1:0] mem [K];

   // Operand storage is deliberately left unreset; the read port gates it.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_data  <= rd_en ? mem[rd_idx] : '0;
      end
   end
endmodule

// File: rtl/sa_skew_feeder.sv
// Operand skew feeder for an NxN systolic array: serial load, diagonal stream,
// drain, then a one-cycle result_ld pulse. Define SA_REPLAY_EN for the keep input.
module sa_skew_feeder import sa_pkg::*; #(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int N          = 4,
   parameter int K          = 4,
   parameter int PE_LAT     = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ld_valid,
   input  logic [DATA_WIDTH-1:0]   ld_data,
   output logic                    ld_ready,
   input  logic                    start,
   output logic                    full,
   output logic                    busy,
   output logic [N*DATA_WIDTH-1:0] sa_out,
   output logic [N-1:0]            sa_valid,
   output logic                    result_ld
`ifdef SA_REPLAY_EN
   ,
   input  logic                    keep
`endif
);
   // state  | meaning
   // LOAD   | accepting lane-major words, ld_ready high
   // FULL   | all N*K words held, waiting for start
   // STREAM | issue counter t sweeps 0..K+N-2, lane i reads word t-i
   // DRAIN  | lanes idle while the wavefront leaves the array
   // DONE   | one cycle, result_ld high; back to LOAD (or FULL with keep)

   localparam int NK = N * K;
   localparam int PW = $clog2(NK);
   localparam int TW = $clog2(K + N);
   localparam int CW = $clog2(N + PE_LAT);
   localparam int IW = lane_idx(K);
   localparam int LW = lane_idx(N);

   localparam logic [PW-1:0] PTR_LAST   = PW'(NK - 1);
   localparam logic [TW-1:0] T_LAST     = TW'(K + N - 2);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(N - 1 + PE_LAT);

   sa_state_e     state;
   sa_state_e     next_state;
   logic [PW-1:0] wr_ptr;
   logic [TW-1:0] t_cnt;
   logic [CW-1:0] drain_cnt;
   logic [LW-1:0] wr_lane;
   logic [IW-1:0] wr_word;
   logic          accept;
   logic          keep_contents;

   assign accept  = ld_valid && ld_ready;
   assign wr_lane = LW'(32'(wr_ptr) / K);
   assign wr_word = IW'(32'(wr_ptr) % K);

`ifdef SA_REPLAY_EN
   assign keep_contents = keep;
`else
   assign keep_contents = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         LOAD:    if (accept && (wr_ptr == PTR_LAST)) next_state = FULL;
         FULL:    if (start) next_state = STREAM;
         STREAM:  if (t_cnt == T_LAST) next_state = DRAIN;
         DRAIN:   if (drain_cnt == '0) next_state = DONE;
         DONE:    next_state = keep_contents ? FULL : LOAD;
         default: next_state = LOAD;
      endcase
   end

   // DRAIN spans N+PE_LAT state cycles: its first cycle still presents the
   // last registered operand, the remaining N-1+PE_LAT cycles are the drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= LOAD;
         wr_ptr    <= '0;
         t_cnt     <= '0;
         drain_cnt <= '0;
      end else begin
         state <= next_state;
         if (accept) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (state == FULL)        t_cnt <= '0;
         else if (state == STREAM) t_cnt <= t_cnt + 1'b1;
         if (state == STREAM)
            drain_cnt <= DRAIN_LOAD;
         else if ((state == DRAIN) && (drain_cnt != '0))
            drain_cnt <= drain_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_ready  <= 1'b1;
         full      <= 1'b0;
         busy      <= 1'b0;
         result_ld <= 1'b0;
      end else begin
         ld_ready  <= (next_state == LOAD);
         full      <= (next_state == FULL);
         busy      <= (next_state == STREAM) || (next_state == DRAIN);
         result_ld <= (next_state == DONE);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic          rd_en;
      logic [IW-1:0] rd_idx;
      logic          wr_en;

      assign wr_en = accept && (wr_lane == LW'(i));

      always_comb begin
         int d;
         d      = int'(t_cnt) - i;
         rd_en  = 1'b0;
         rd_idx = '0;
         if ((state == STREAM) && (d >= 0) && (d < K)) begin
            rd_en  = 1'b1;
            rd_idx = IW'(d);
         end
      end

      sa_lane_buffer #(
         .DATA_WIDTH (DATA_WIDTH),
         .K          (K)
      ) u_buf (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (wr_en),
         .wr_idx   (wr_word),
         .wr_data  (ld_data),
         .rd_en    (rd_en),
         .rd_idx   (rd_idx),
         .rd_data  (sa_out[i*DATA_WIDTH +: DATA_WIDTH]),
         .rd_valid (sa_valid[i])
      );
   end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: a 4x4 instance for load/stream/reset/replay
// scenarios and an 8x2 instance with PE_LAT=3 for the wider-array timing.
module tb_sa_skew_feeder;
   localparam int DW        = 16;
   localparam int N         = 4;
   localparam int K         = 4;
   localparam int PL        = 1;
   localparam int RES_CYC   = K + 2*N - 1 + PL;
   localparam int NB        = 8;
   localparam int KB        = 2;
   localparam int PB        = 3;
   localparam int RES_CYC_B = KB + 2*NB - 1 + PB;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          ld_valid, start, ld_ready, full, busy, result_ld;
   logic [DW-1:0] ld_data;
   logic [N*DW-1:0] sa_out;
   logic [N-1:0]    sa_valid;
`ifdef SA_REPLAY_EN
   logic keep;
`endif

   sa_skew_feeder #(.DATA_WIDTH(DW), .N(N), .K(K), .PE_LAT(PL)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .start(start), .full(full), .busy(busy), .sa_out(sa_out), .sa_valid(sa_valid),
      .result_ld(result_ld)
`ifdef SA_REPLAY_EN
      , .keep(keep)
`endif
   );

   logic           ld_valid_b, start_b, ld_ready_b, full_b, busy_b, result_ld_b;
   logic [DW-1:0]  ld_data_b;
   logic [NB*DW-1:0] sa_out_b;
   logic [NB-1:0]    sa_valid_b;

   sa_skew_feeder #(.DATA_WIDTH(DW), .N(NB), .K(KB), .PE_LAT(PB)) dut_b (
      .clk(clk), .rst(rst), .ld_valid(ld_valid_b), .ld_data(ld_data_b), .ld_ready(ld_ready_b),
      .start(start_b), .full(full_b), .busy(busy_b), .sa_out(sa_out_b), .sa_valid(sa_valid_b),
      .result_ld(result_ld_b)
`ifdef SA_REPLAY_EN
      , .keep(1'b0)
`endif
   );

   int vectors = 0;
   int errors  = 0;
   logic [DW-1:0] exp_mem [N][K];
   logic [DW-1:0] lane_q  [N][$];
   int            cyc_q   [N][$];

   task automatic load_all(input int base, input bit gap, input bit poke_start, input bit offer_extra);
      int w   = 0;
      int cyc = 0;
      while (w < N*K && cyc < 200) begin
         @(negedge clk);
         ld_valid = !(gap && (cyc % 2 == 1));
         ld_data  = DW'(base + w);
         start    = poke_start && (w == 5);
         vectors++;
         if (ld_ready !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL load_ready word %0d: ld_ready=%b full=%b, want 1/0", w, ld_ready, full);
         end
         if (ld_valid) begin
            exp_mem[w / K][w % K] = ld_data;
            w++;
         end
         cyc++;
      end
      vectors++;
      if (w != N*K) begin
         errors++;
         $display("FAIL load_timeout: %0d words offered, want %0d", w, N*K);
      end
      @(negedge clk);
      ld_valid = offer_extra;
      ld_data  = 16'hDEAD;
      start    = 1'b0;
      vectors++;
      if (full !== 1'b1 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_full: full=%b ld_ready=%b, want 1/0", full, ld_ready);
      end
      if (offer_extra) begin
         repeat (3) begin
            @(negedge clk);
            vectors++;
            if (ld_ready !== 1'b0) begin
               errors++;
               $display("FAIL full_blocks_load: ld_ready=%b, want 0", ld_ready);
            end
         end
      end
      ld_valid = 1'b0;
   endtask

   task automatic run_stream(input bit poke_start, input bit keep_after);
      int            pulses = 0;
      logic [DW-1:0] got;
      logic [DW-1:0] want;
      int            want_c;
      @(negedge clk);
      vectors++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL pre_start_full: full=%b, want 1", full);
      end
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < K; k++) begin
            lane_q[i].push_back(exp_mem[i][k]);
            cyc_q[i].push_back(i + 1 + k);
         end
      end
      start = 1'b1;
`ifdef SA_REPLAY_EN
      keep = keep_after;
`endif
      @(posedge clk);
      for (int c = 0; c <= RES_CYC + 2; c++) begin
         @(negedge clk);
         start = poke_start && (c == 2);
         for (int i = 0; i < N; i++) begin
            got = sa_out[i*DW +: DW];
            vectors++;
            if (sa_valid[i]) begin
               if (lane_q[i].size() == 0) begin
                  errors++;
                  $display("FAIL lane%0d_extra: valid with %h at cycle %0d, want idle", i, got, c);
               end else begin
                  want   = lane_q[i].pop_front();
                  want_c = cyc_q[i].pop_front();
                  if (got !== want || c != want_c) begin
                     errors++;
                     $display("FAIL lane%0d_data: got %h at cycle %0d, want %h at cycle %0d", i, got, c, want, want_c);
                  end
               end
            end else if (got !== '0) begin
               errors++;
               $display("FAIL lane%0d_gate: got %h at cycle %0d while invalid, want 0", i, got, c);
            end
         end
         vectors++;
         if (result_ld !== (c == RES_CYC)) begin
            errors++;
            $display("FAIL result_ld: got %b at cycle %0d, want %b", result_ld, c, (c == RES_CYC));
         end
         if (result_ld === 1'b1) pulses++;
         vectors++;
         if (busy !== (c < RES_CYC)) begin
            errors++;
            $display("FAIL busy: got %b at cycle %0d, want %b", busy, c, (c < RES_CYC));
         end
         vectors++;
         if (ld_ready !== (!keep_after && c > RES_CYC) || full !== (keep_after && c > RES_CYC)) begin
            errors++;
            $display("FAIL post_done: ld_ready=%b full=%b at cycle %0d, want %b/%b", ld_ready, full, c,
                     (!keep_after && c > RES_CYC), (keep_after && c > RES_CYC));
         end
      end
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         vectors++;
         if (lane_q[i].size() != 0) begin
            errors++;
            $display("FAIL lane%0d_missing: %0d operands never issued, want 0", i, lane_q[i].size());
            lane_q[i].delete();
            cyc_q[i].delete();
         end
      end
      vectors++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL result_pulses: got %0d, want 1", pulses);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if (ld_ready !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || result_ld !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ld_ready=%b full=%b busy=%b result_ld=%b, want 1/0/0/0",
                  ld_ready, full, busy, result_ld);
      end
      vectors++;
      if (sa_valid !== '0 || sa_out !== '0) begin
         errors++;
         $display("FAIL reset_lanes: sa_valid=%b sa_out=%h, want 0/0", sa_valid, sa_out);
      end
      vectors++;
      if (ld_ready_b !== 1'b1 || sa_valid_b !== '0) begin
         errors++;
         $display("FAIL reset_b: ld_ready=%b sa_valid=%b, want 1/0", ld_ready_b, sa_valid_b);
      end
      rst = 1'b1;
   endtask

   task automatic test_basic_stream();
      load_all(1, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0, 1'b0);
   endtask

   task automatic test_ignored_start();
      load_all(1, 1'b0, 1'b1, 1'b0);
      run_stream(1'b1, 1'b0);
   endtask

   task automatic test_gapped_load();
      load_all(300, 1'b1, 1'b0, 1'b1);
      run_stream(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_stream();
      load_all(200, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (sa_valid !== 4'b0111) begin
         errors++;
         $display("FAIL mid_stream_valid: sa_valid=%b at cycle 3, want 0111", sa_valid);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (ld_ready !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || result_ld !== 1'b0 ||
          sa_valid !== '0 || sa_out !== '0) begin
         errors++;
         $display("FAIL abort_reset: ld_ready=%b full=%b busy=%b result_ld=%b sa_valid=%b sa_out=%h, want 1/0/0/0/0/0",
                  ld_ready, full, busy, result_ld, sa_valid, sa_out);
      end
      @(negedge clk);
      rst = 1'b1;
      load_all(1, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0, 1'b0);
   endtask

`ifdef SA_REPLAY_EN
   task automatic test_replay();
      load_all(500, 1'b0, 1'b0, 1'b0);
      run_stream(1'b0, 1'b1);
      run_stream(1'b0, 1'b0);
   endtask
`endif

   task automatic test_dims_8x2();
      logic [DW-1:0] q [$];
      logic [DW-1:0] want;
      for (int w = 0; w < NB*KB; w++) begin
         @(negedge clk);
         ld_valid_b = 1'b1;
         ld_data_b  = DW'(100 + w);
         vectors++;
         if (ld_ready_b !== 1'b1) begin
            errors++;
            $display("FAIL b_load_ready word %0d: got %b, want 1", w, ld_ready_b);
         end
         if (w / KB == NB - 1) q.push_back(ld_data_b);
      end
      @(negedge clk);
      ld_valid_b = 1'b0;
      vectors++;
      if (full_b !== 1'b1) begin
         errors++;
         $display("FAIL b_full: got %b, want 1", full_b);
      end
      start_b = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= RES_CYC_B + 1; c++) begin
         @(negedge clk);
         start_b = 1'b0;
         vectors++;
         if (sa_valid_b[NB-1] !== (c >= NB && c <= NB + KB - 1)) begin
            errors++;
            $display("FAIL b_lane7_valid: got %b at cycle %0d, want %b", sa_valid_b[NB-1], c,
                     (c >= NB && c <= NB + KB - 1));
         end
         if (sa_valid_b[NB-1] === 1'b1 && q.size() > 0) begin
            want = q.pop_front();
            vectors++;
            if (sa_out_b[(NB-1)*DW +: DW] !== want) begin
               errors++;
               $display("FAIL b_lane7_data: got %h at cycle %0d, want %h", sa_out_b[(NB-1)*DW +: DW], c, want);
            end
         end
         vectors++;
         if (result_ld_b !== (c == RES_CYC_B)) begin
            errors++;
            $display("FAIL b_result_ld: got %b at cycle %0d, want %b", result_ld_b, c, (c == RES_CYC_B));
         end
      end
      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL b_lane7_missing: %0d operands never issued, want 0", q.size());
      end
   endtask

   initial begin
      rst        = 1'b0;
      ld_valid   = 1'b0;
      ld_data    = '0;
      start      = 1'b0;
      ld_valid_b = 1'b0;
      ld_data_b  = '0;
      start_b    = 1'b0;
`ifdef SA_REPLAY_EN
      keep       = 1'b0;
`endif
      test_reset();
      test_basic_stream();
      test_ignored_start();
      test_gapped_load();
      test_reset_mid_stream();
`ifdef SA_REPLAY_EN
      test_replay();
`endif
      test_dims_8x2();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
